phy_tx_serializer: RTL and testbench
====================================

Name: phy_tx_serializer

Overview:
- Transmit end of the serial PHY link. Takes four parallel 8-bit lanes with per-lane valid and interleaves them byte by byte into one serial bit stream at clk_32f. The stream is what the receive PHY deserializes back onto out0..out3 / val_out0..val_out3.
- Invalid lanes are filled with the COM/idle symbol so the receiver can acquire and keep byte alignment.
- Sits between the lane-side logic and the serial line (salida_tx feeds entrada_tx of the receiver).

Parameters:
- IDLE_BYTE, 8'hBC, symbol sent in any lane slot whose valid is low; also the reset frame content.
- MSB_FIRST, 1, 1 = each byte is shifted out bit 7 first; 0 = bit 0 first.

Ports:
- clk_32f  input  1  serial bit clock, one bit per rising edge.
- rst  input  1  synchronous, active-high reset.
- in0  input  8  lane 0 data.
- in1  input  8  lane 1 data.
- in2  input  8  lane 2 data.
- in3  input  8  lane 3 data.
- valid0..valid3  input  1 each  lane data valid, sampled at frame load.
- salida_tx  output  1  serial line out.
- tx_ack  output  1  one-cycle pulse; lane inputs were captured on this edge.
- frame_start  output  1  high while the first bit of a frame is on salida_tx.

Behaviour:
- Single clock domain, clk_32f rising edge. Reset is synchronous and active-high; rst is sampled only on the clock edge.
- State:
  - 5-bit bit counter cnt (0..31, wraps 31->0).
  - 32-bit shift register sh.
- Reset, synchronous, rst=1 at the edge:
  - cnt=0, sh={IDLE_BYTE x4}, tx_ack=0.
  - salida_tx = MSB of IDLE_BYTE (1 for 0xBC).
  - frame_start=1, since cnt=0.
- Frame layout, 32 clk_32f cycles, bit slot = cnt:
  - lane 0 in slots 0-7, lane 1 in 8-15, lane 2 in 16-23, lane 3 in 24-31.
  - Bit order within each byte per MSB_FIRST.
- Each edge with rst=0:
  - cnt <= cnt+1 (31 wraps to 0).
  - If cnt==31: load sh with the next frame. Each lane slot holds inN if validN=1, else IDLE_BYTE. tx_ack <= 1.
  - Otherwise: shift sh by one bit toward the output end. tx_ack <= 0.
- Outputs:
  - salida_tx is driven directly from the output bit of sh (flop output, no combinational path from inputs).
  - frame_start = (cnt==0).
- Latency: inputs present at the edge ending cnt==31 appear on salida_tx starting the next cycle (slot 0). The lane 3 last bit leaves 32 cycles after capture.
- Inputs are sampled only at load. Changes between loads are ignored, so lane data must be held until tx_ack.
- The first frame after reset is always all IDLE_BYTE. The first user data is captured at the 32nd edge after rst deasserts.
- Data byte equal to IDLE_BYTE with valid=1 is transmitted unchanged. Disambiguation is not this block's job.
- Reset mid-frame: the partial frame is discarded and the next cycle restarts at slot 0 with the idle frame. No partial byte is emitted.
- rst asserted on the same edge as cnt==31: reset wins, no capture, tx_ack stays 0.

Optional Feature:
- Macro: PHY_TX_STATS_EN.
- Defined:
  - Adds output frames_sent [15:0], reset 0.
  - Increments by 1 on each load edge where at least one validN=1.
  - Saturates at 16'hFFFF (no wrap).
- Not defined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, all valids 0. Result: salida_tx repeats 10111100 every 8 cycles indefinitely; frame_start high every 32nd cycle; tx_ack period 32.
- Single lane: in0=8'hFF, valid0=1, others 0, held. Result: tx_ack at the 32nd edge after reset release. Next frame = 11111111 10111100 10111100 10111100.
- All lanes: in0..in3 = 8'h01, 8'h80, 8'hA5, 8'h3C, all valid. Result: frame bits 00000001 10000000 10100101 00111100; MSB_FIRST=0 build gives 10000000 00000001 10100101 00111100.
- Input change mid-frame: change in1 at slot 10. Result: the current frame is unaffected and the new value appears only in the frame after the next tx_ack.
- Reset at slot 13 of a data frame. Result: the next cycle has frame_start=1 and salida_tx=1, the remainder of the data frame never appears, and tx_ack returns 32 edges later.
- PHY_TX_STATS_EN: 5 frames with valid2=1 and 3 all-invalid frames give frames_sent=5. Preloading the counter to 16'hFFFE by force and sending 3 valid frames gives 16'hFFFF.

Source files
------------

// File: rtl/phy_tx_serializer.sv
// phy_tx_serializer: interleaves four 8-bit lanes into a 32-bit serial frame on clk_32f, with idle fill.
// Optional PHY_TX_STATS_EN adds a saturating frames_sent counter.
module phy_tx_serializer #(
   parameter logic [7:0] IDLE_BYTE = 8'hBC,
   parameter bit         MSB_FIRST = 1'b1
) (
   input  logic        clk_32f,
   input  logic        rst,
   input  logic [7:0]  in0,
   input  logic [7:0]  in1,
   input  logic [7:0]  in2,
   input  logic [7:0]  in3,
   input  logic        valid0,
   input  logic        valid1,
   input  logic        valid2,
   input  logic        valid3,
   output logic        salida_tx,
   output logic        tx_ack,
   output logic        frame_start
`ifdef PHY_TX_STATS_EN
   ,
   output logic [15:0] frames_sent
`endif
);
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] sh_q, sh_d, frame;
   logic        tx_ack_q, tx_ack_d, load;
   logic [7:0]  b0, b1, b2, b3;
   always_comb begin
      b0 = valid0 ? in0 : IDLE_BYTE;
      b1 = valid1 ? in1 : IDLE_BYTE;
      b2 = valid2 ? in2 : IDLE_BYTE;
      b3 = valid3 ? in3 : IDLE_BYTE;
      // lane 0 always sits at the output end of the shift register
      frame = MSB_FIRST ? {b0, b1, b2, b3} : {b3, b2, b1, b0};
      load = cnt_q == 5'd31;
      cnt_d = cnt_q + 5'd1;
      tx_ack_d = load;
      sh_d = load ? frame : MSB_FIRST ? {sh_q[30:0], 1'b0} : {1'b0, sh_q[31:1]};
   end
   always_ff @(posedge clk_32f) begin
      if (rst) begin
         cnt_q <= 5'd0;
         sh_q <= {4{IDLE_BYTE}};
         tx_ack_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         sh_q <= sh_d;
         tx_ack_q <= tx_ack_d;
      end
   end
   assign salida_tx = MSB_FIRST ? sh_q[31] : sh_q[0];
   assign frame_start = cnt_q == 5'd0;
   assign tx_ack = tx_ack_q;
`ifdef PHY_TX_STATS_EN
   logic [15:0] frames_q, frames_d;
   always_comb begin
      frames_d = (load && (valid0 | valid1 | valid2 | valid3) && frames_q != 16'hFFFF) ? frames_q + 16'd1 : frames_q;
   end
   always_ff @(posedge clk_32f) begin
      if (rst) frames_q <= 16'd0;
      else frames_q <= frames_d;
   end
   assign frames_sent = frames_q;
`endif
endmodule

// File: tb/tb_phy_tx_serializer.sv
// tb_phy_tx_serializer: directed + random stimulus against a byte/slot frame model of the serializer.
module tb_phy_tx_serializer;
   localparam logic [7:0] IDLE = 8'hBC;
   localparam bit         MSB  = 1'b1;
   logic       clk_32f = 1'b0;
   logic       rst;
   logic [7:0] in0, in1, in2, in3;
   logic       valid0, valid1, valid2, valid3;
   logic       salida_tx, tx_ack, frame_start;
`ifdef PHY_TX_STATS_EN
   logic [15:0] frames_sent;
`endif
   int total = 0;
   int bad = 0;
   logic [7:0]  fr [4];
   int          slot;
   logic        ack_exp;
   logic [31:0] got, last_frame;

   phy_tx_serializer #(.IDLE_BYTE(IDLE), .MSB_FIRST(MSB)) dut (
      .clk_32f(clk_32f), .rst(rst),
      .in0(in0), .in1(in1), .in2(in2), .in3(in3),
      .valid0(valid0), .valid1(valid1), .valid2(valid2), .valid3(valid3),
      .salida_tx(salida_tx), .tx_ack(tx_ack), .frame_start(frame_start)
`ifdef PHY_TX_STATS_EN
      , .frames_sent(frames_sent)
`endif
   );

   always #5 clk_32f = ~clk_32f;

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      int bi;
      @(posedge clk_32f);
      if (rst) begin
         slot = 0;
         fr = '{IDLE, IDLE, IDLE, IDLE};
         ack_exp = 1'b0;
      end else begin
         ack_exp = (slot == 31);
         if (slot == 31) begin
            fr[0] = valid0 ? in0 : IDLE;
            fr[1] = valid1 ? in1 : IDLE;
            fr[2] = valid2 ? in2 : IDLE;
            fr[3] = valid3 ? in3 : IDLE;
         end
         slot = (slot + 1) % 32;
      end
      #1;
      bi = MSB ? 7 - (slot % 8) : slot % 8;
      chk("salida_tx", 32'(salida_tx), 32'(fr[slot / 8][bi]));
      chk("frame_start", 32'(frame_start), 32'(slot == 0));
      chk("tx_ack", 32'(tx_ack), 32'(ack_exp));
      got = {got[30:0], salida_tx};
      if (slot == 31) last_frame = got;
   endtask

   task automatic randomize_inputs();
      in0 = 8'($urandom); in1 = 8'($urandom); in2 = 8'($urandom); in3 = 8'($urandom);
      {valid0, valid1, valid2, valid3} = 4'($urandom);
   endtask

   initial begin
      slot = 0; ack_exp = 1'b0; got = '0; last_frame = '0;
      fr = '{IDLE, IDLE, IDLE, IDLE};
      in0 = '0; in1 = '0; in2 = '0; in3 = '0;
      {valid0, valid1, valid2, valid3} = 4'b0;
      rst = 1'b1;
      step(); step();
      chk("reset_salida", 32'(salida_tx), 32'd1);
      chk("reset_frame_start", 32'(frame_start), 32'd1);
      chk("reset_tx_ack", 32'(tx_ack), 32'd0);
      rst = 1'b0;
      repeat (64) step();
      chk("idle_frame", last_frame, 32'hBCBCBCBC);
      // single lane, data held across reset release
      rst = 1'b1; in0 = 8'hFF; valid0 = 1'b1;
      step();
      rst = 1'b0;
      repeat (31) step();
      chk("ack_before_32", 32'(tx_ack), 32'd0);
      chk("first_frame_idle", last_frame, 32'hBCBCBCBC);
      step();
      chk("ack_at_32", 32'(tx_ack), 32'd1);
      repeat (31) step();
      chk("single_lane_frame", last_frame, 32'hFFBCBCBC);
      // all lanes valid; slot is 31 so the next edge loads
      in0 = 8'h01; in1 = 8'h80; in2 = 8'hA5; in3 = 8'h3C;
      {valid0, valid1, valid2, valid3} = 4'hF;
      step();
      chk("all_lanes_ack", 32'(tx_ack), 32'd1);
      repeat (10) step();
      in1 = 8'h55;
      repeat (21) step();
      chk("all_lanes_frame", last_frame, 32'h0180A53C);
      repeat (32) step();
      chk("changed_lane_frame", last_frame, 32'h0155A53C);
      // idle byte sent as data when valid
      in2 = IDLE; valid1 = 1'b0;
      repeat (32) step();
      chk("idle_as_data", last_frame, 32'h01BCBC3C);
      // random traffic, inputs also change between loads
      for (int i = 0; i < 480; i++) begin
         if ($urandom_range(0, 3) == 0) randomize_inputs();
         step();
      end
      // reset in slot 13 of a data frame
      {valid0, valid1, valid2, valid3} = 4'hF;
      for (int i = 0; i < 64 && slot != 13; i++) step();
      chk("reached_slot13", 32'(slot), 32'd13);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst13_frame_start", 32'(frame_start), 32'd1);
      chk("rst13_salida", 32'(salida_tx), 32'd1);
      repeat (31) step();
      chk("rst13_idle_frame", last_frame, 32'hBCBCBCBC);
      step();
      chk("rst13_ack_32", 32'(tx_ack), 32'd1);
      // reset coinciding with the load edge
      for (int i = 0; i < 64 && slot != 31; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_on_load_no_ack", 32'(tx_ack), 32'd0);
      repeat (40) step();
`ifdef PHY_TX_STATS_EN
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("stats_reset", 32'(frames_sent), 32'd0);
      {valid0, valid1, valid2, valid3} = 4'b0010;
      repeat (160) step();
      {valid0, valid1, valid2, valid3} = 4'b0000;
      repeat (96) step();
      chk("stats_count", 32'(frames_sent), 32'd5);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
